// File: rtl/camera_stream_gen.sv
// OV7670-style pixel-stream source: VSYNC/HREF framing and RGB565 bytes from a built-in pattern.
// Stands in for the sensor so the capture, VGA and image-processing path can run without a camera.
module camera_stream_gen #(
   parameter int IMG_WIDTH  = 176,
   parameter int IMG_HEIGHT = 144,
   parameter int VSYNC_LEN  = 4,
   parameter int V_BACK     = 10,
   parameter int H_BLANK    = 16,
   parameter int V_FRONT    = 10
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       EN,
   input  logic [1:0] PATTERN_SEL,
   output logic       VSYNC,
   output logic       HREF,
   output logic [7:0] DATA,
   output logic       FRAME_DONE,
   output logic [7:0] FRAME_CNT
);
   localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int MAX_AB = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
   localparam int MAX_CD = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
   localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

   localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   typedef enum logic [2:0] {IDLE, VS, VBP, LINE, HBL, VFP} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [XW-1:0]   x, x_nx;
   logic [YW-1:0]   y, y_nx;
   logic            ph, ph_nx;
   logic [1:0]      pat, pat_nx;
   logic [2:0]      bar_idx;
   logic [15:0]     pix;
   logic            vsync_d, href_d, done_d;
   logic [7:0]      data_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         cnt        <= '0;
         x          <= '0;
         y          <= '0;
         ph         <= 1'b0;
         pat        <= 2'd0;
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         DATA       <= 8'h00;
         FRAME_DONE <= 1'b0;
         FRAME_CNT  <= 8'h00;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         x          <= x_nx;
         y          <= y_nx;
         ph         <= ph_nx;
         pat        <= pat_nx;
         VSYNC      <= vsync_d;
         HREF       <= href_d;
         DATA       <= data_d;
         FRAME_DONE <= done_d;
         if (done_d) FRAME_CNT <= FRAME_CNT + 8'd1;
      end
   end

   // EN and PATTERN_SEL only matter at a frame boundary, so frames are never truncated.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CW'(1);
      x_nx     = x;
      y_nx     = y;
      ph_nx    = ph;
      pat_nx   = pat;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (EN) begin
               state_nx = VS;
               pat_nx   = PATTERN_SEL;
            end
         end
         VS: if (cnt == CW'(VSYNC_LEN - 1)) begin
            state_nx = VBP;
            cnt_nx   = '0;
         end
         VBP: if (cnt == CW'(V_BACK - 1)) begin
            state_nx = LINE;
            cnt_nx   = '0;
            x_nx     = '0;
            y_nx     = '0;
            ph_nx    = 1'b0;
         end
         LINE: begin
            cnt_nx = '0;
            ph_nx  = ~ph;
            if (ph) x_nx = x + XW'(1);
            if (ph && x == XW'(IMG_WIDTH - 1)) begin
               state_nx = HBL;
               x_nx     = '0;
               ph_nx    = 1'b0;
            end
         end
         HBL: if (cnt == CW'(H_BLANK - 1)) begin
            cnt_nx = '0;
            if (y == YW'(IMG_HEIGHT - 1)) begin
               state_nx = VFP;
            end else begin
               state_nx = LINE;
               y_nx     = y + YW'(1);
            end
         end
         VFP: if (cnt == CW'(V_FRONT - 1)) begin
            cnt_nx = '0;
            if (EN) begin
               state_nx = VS;
               pat_nx   = PATTERN_SEL;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed from the next state so the registered pins line up with it.
   always_comb begin
      bar_idx = 3'((16'(x_nx) << 3) / 16'(IMG_WIDTH));
      case (pat_nx)
         2'd0:    pix = 16'hF800;
         2'd1:    pix = 16'h07E0;
         2'd2:    pix = 16'h001F;
         default: pix = BAR_RGB[bar_idx];
      endcase
      vsync_d = (state_nx == VS);
      href_d  = (state_nx == LINE);
      data_d  = href_d ? (ph_nx ? pix[7:0] : pix[15:8]) : 8'h00;
      done_d  = (state_nx == VFP) && (cnt_nx == CW'(V_FRONT - 1));
   end
endmodule

// File: doc/camera_stream_gen.md
# camera_stream_gen

Synthesizable OV7670-style pixel-stream transmitter: drives VSYNC, HREF and an 8-bit RGB565 byte bus frame after frame from a built-in test pattern. It is the source end of the camera capture path, which samples these signals, downsamples RGB565 to RGB332 and writes the M9K frame buffer. It replaces the physical camera for on-FPGA bring-up and bench verification of the capture, VGA and image-processor chain.

## Interface
- IMG_WIDTH, 176: active pixels per line; each pixel is 2 bytes.
- IMG_HEIGHT, 144: active lines per frame.
- VSYNC_LEN, 4: cycles VSYNC is held high per frame (must be ≥1).
- V_BACK, 10: idle cycles after VSYNC falls, before the first line (≥1).
- H_BLANK, 16: HREF-low cycles after every line, including the last (≥1).
- V_FRONT, 10: idle cycles after the last line's H_BLANK, before frame end (≥1).

- CLK  in  1  byte clock; one byte is transferred per cycle. The sink samples on the same edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  run request; sampled only in IDLE and at frame end.
- PATTERN_SEL  in  2  0 solid red, 1 solid green, 2 solid blue, 3 eight vertical colour bars.
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  high while DATA carries active bytes.
- DATA  out  8  RGB565 byte; 0x00 whenever HREF is low.
- FRAME_DONE  out  1  one-cycle pulse on the last V_FRONT cycle.
- FRAME_CNT  out  8  completed frames; wraps 255→0.

## Operation
- State machine states: IDLE, VS, VBP, LINE, HBL, VFP.
  - IDLE & EN → VS.
  - VS: VSYNC_LEN cycles, then → VBP.
  - VBP: V_BACK cycles, then → LINE.
  - LINE: 2·IMG_WIDTH cycles, then → HBL.
  - HBL: H_BLANK cycles, then → LINE if lines remain, else → VFP.
  - VFP: V_FRONT cycles, then → VS if EN, else → IDLE.
- PATTERN_SEL is latched on entry to VS and is constant for the whole frame.
- Byte order per pixel follows OV7670 RGB565:
  - even byte {R[4:0], G[5:3]};
  - odd byte {G[2:0], B[4:0]}.
- Solid colours: red 0xF800, green 0x07E0, blue 0x001F.
- Colour bars:
  - Bar index is b = (x·8)/IMG_WIDTH, computed with a 16-bit intermediate, for x = 0..IMG_WIDTH-1.
  - Colours for b = 0..7: 0xFFFF white, 0xFFE0 yellow, 0x07FF cyan, 0x07E0 green, 0xF81F magenta, 0xF800 red, 0x001F blue, 0x0000 black.
  - Bars are identical on every line.
- Counters:
  - byte phase (1 bit);
  - x (clog2(IMG_WIDTH) bits);
  - y (clog2(IMG_HEIGHT) bits);
  - phase-cycle counter sized for the largest of the timing parameters.
  - All counters clear on entry to each state that uses them.
- FRAME_CNT increments in the same cycle FRAME_DONE is high.
- EN deasserted mid-frame: the current frame completes through VFP, then the block enters IDLE. No truncated frames are ever emitted.

## Timing
- All outputs are registered.
- Reset values: VSYNC=0, HREF=0, DATA=0x00, FRAME_DONE=0, FRAME_CNT=0. State is IDLE and all counters are 0.
- RESET has priority over everything, including a frame in progress; outputs reach the reset values on the next edge.
- Start latency: at the edge that samples EN=1 in IDLE, VSYNC goes high for the following cycle. The first HREF-high cycle starts VSYNC_LEN+V_BACK cycles after VSYNC rises.
- HREF and the first byte of each line change on the same edge. HREF is high for exactly 2·IMG_WIDTH consecutive cycles per line.
- VSYNC and HREF are never high in the same cycle.
- Frame period is VSYNC_LEN + V_BACK + IMG_HEIGHT·(2·IMG_WIDTH + H_BLANK) + V_FRONT cycles. With EN held high, the next VSYNC rises in the cycle after FRAME_DONE.
- Default frame period: 4+10+144·368+10 = 53016 cycles.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=2, H_BLANK=2, VSYNC_LEN=2, V_BACK=3, V_FRONT=3 unless stated; the resulting frame period is 44 cycles.
- Reset, then EN=0 for 50 cycles → all outputs hold 0, no VSYNC.
- EN=1, PATTERN_SEL=0:
  - VSYNC high for 2 cycles;
  - after 3 idle cycles, HREF high for 16 cycles with DATA alternating 0xF8, 0x00;
  - 2 blank cycles, then the second line;
  - FRAME_DONE pulses at cycle 44 of the frame and FRAME_CNT becomes 1.
- PATTERN_SEL=3:
  - Line bytes are FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
  - Rerun with IMG_WIDTH=176: the pixel at x=21 is white and the pixel at x=22 is yellow.
- Change PATTERN_SEL from 0 to 2 mid-frame → the current frame stays red; the next frame's bytes are 0x00, 0x1F.
- Drop EN during line 0 → the frame completes, FRAME_DONE pulses once, the block enters IDLE and VSYNC stays low.
- Assert RESET for 1 cycle in the middle of HREF → the next cycle has HREF=0, DATA=0 and FRAME_CNT=0. With EN=1, the next VSYNC rises one cycle after RESET falls.
